// File: rtl/axi_burst_write_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_pkg
//  Description : Shared AXI4 write-burst constants, FSM state type and the
//                AWSIZE helper used by the burst write master.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_pkg;

    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        RESP  = 2'd2
    } state_t;

    // AWSIZE encoding for a full-width beat: log2 of the bytes per beat.
    function automatic logic [2:0] axi_size(input int data_w);
        return 3'($clog2(data_w / 8));
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_burst_write_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi_burst_write_if
//  Description : AXI4 write-only channel bundle (AW, W, B) between the burst
//                write master and the memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
interface axi_burst_write_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int LEN_W  = 8
);
    logic                  AWVALID;
    logic                  AWREADY;
    logic [ADDR_W-1:0]     AWADDR;
    logic [LEN_W-1:0]      AWLEN;
    logic [2:0]            AWSIZE;
    logic [1:0]            AWBURST;

    logic                  WVALID;
    logic                  WREADY;
    logic [DATA_W-1:0]     WDATA;
    logic [DATA_W/8-1:0]   WSTRB;
    logic                  WLAST;

    logic                  BVALID;
    logic                  BREADY;
    logic [1:0]            BRESP;

    modport master (
        output AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST,
        output WVALID, WDATA, WSTRB, WLAST,
        output BREADY,
        input  AWREADY, WREADY, BVALID, BRESP
    );

    modport slave (
        input  AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST,
        input  WVALID, WDATA, WSTRB, WLAST,
        input  BREADY,
        output AWREADY, WREADY, BVALID, BRESP
    );
endinterface
`default_nettype wire

// File: rtl/axi_burst_write_w_stage.sv
`default_nettype none
// ============================================================================
//  Module      : axi_w_stage
//  Description : Registered W-channel slice. Accepts data beats from the
//                LSU/DMA side, counts them and flags the final beat with WLAST.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_w_stage #(
    parameter int DATA_W = 64,
    parameter int LEN_W  = 8
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                i_start,
    input  wire logic                i_active,
    input  wire logic [LEN_W-1:0]    i_len,
    input  wire logic                i_wd_valid,
    input  wire logic [DATA_W-1:0]   i_wd_data,
    input  wire logic [DATA_W/8-1:0] i_wd_strb,
    input  wire logic                i_wready,
    output logic                     o_wd_ready,
    output logic                     o_wvalid,
    output logic [DATA_W-1:0]        o_wdata,
    output logic [DATA_W/8-1:0]      o_wstrb,
    output logic                     o_wlast,
    output logic                     o_w_done_next
);

    logic [LEN_W:0]      r_count;
    logic                r_wvalid;
    logic                r_wlast;
    logic                r_w_done;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_wstrb;

    logic                w_wd_ready;
    logic                w_accept;
    logic                w_w_hs;

    // The count guard stops a further beat being taken while the last one
    // is still waiting in the slice for WREADY.
    assign w_w_hs     = r_wvalid & i_wready;
    assign w_wd_ready = i_active & ~r_w_done & (r_count <= {1'b0, i_len})
                      & (~r_wvalid | i_wready);
    assign w_accept   = i_wd_valid & w_wd_ready;

    // Beat slice register, beat counter and W completion flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= '0;
            r_wvalid <= 1'b0;
            r_wlast  <= 1'b0;
            r_w_done <= 1'b0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
        end else if (i_start) begin
            r_count  <= '0;
            r_wvalid <= 1'b0;
            r_wlast  <= 1'b0;
            r_w_done <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wvalid <= 1'b1;
                r_wdata  <= i_wd_data;
                r_wstrb  <= i_wd_strb;
                r_wlast  <= (r_count == {1'b0, i_len});
                r_count  <= r_count + 1'b1;
            end else if (w_w_hs) begin
                r_wvalid <= 1'b0;
                r_wlast  <= 1'b0;
            end
            if (w_w_hs & r_wlast) begin
                r_w_done <= 1'b1;
            end
        end
    end

    assign o_wd_ready    = w_wd_ready;
    assign o_wvalid      = r_wvalid;
    assign o_wdata       = r_wdata;
    assign o_wstrb       = r_wstrb;
    assign o_wlast       = r_wlast;
    assign o_w_done_next = r_w_done | (w_w_hs & r_wlast);

endmodule
`default_nettype wire

// File: rtl/axi_burst_write.sv
`default_nettype none
// ============================================================================
//  Module      : axi_burst_write
//  Description : AXI4 INCR burst write master. Takes one burst request,
//                issues AW, streams W beats, collects B and reports done.
//                Misaligned or 4KB-crossing requests are refused locally.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_burst_write
    import axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int LEN_W  = 8
) (
    input  wire logic                ACLK,
    input  wire logic                ARESET,
    input  wire logic                req_valid,
    output logic                     req_ready,
    input  wire logic [ADDR_W-1:0]   req_addr,
    input  wire logic [LEN_W-1:0]    req_len,
    input  wire logic                wd_valid,
    output logic                     wd_ready,
    input  wire logic [DATA_W-1:0]   wd_data,
    input  wire logic [DATA_W/8-1:0] wd_strb,
    output logic                     done,
    output logic [1:0]               resp,
    output logic                     reject,
    axi_burst_write_if.master        axi
);

    localparam int                c_BYTES      = DATA_W / 8;
    localparam logic [2:0]        c_SIZE       = axi_size(DATA_W);
    localparam logic [ADDR_W-1:0] c_ALIGN_MASK = ADDR_W'(c_BYTES - 1);

    state_t              r_state;
    state_t              w_state_next;

    logic                r_aw_valid;
    logic                r_aw_done;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_len;
    logic                r_done;
    logic                r_reject;
    logic [1:0]          r_resp;

    logic                w_req_fire;
    logic                w_misaligned;
    logic [31:0]         w_span;
    logic [31:0]         w_page_end;
    logic                w_cross;
    logic                w_reject;
    logic                w_start;
    logic                w_aw_done_next;
    logic                w_w_done_next;
    logic                w_b_hs;

    logic                w_wvalid;
    logic [DATA_W-1:0]   w_wdata;
    logic [DATA_W/8-1:0] w_wstrb;
    logic                w_wlast;

    // Request screening: the burst must start beat-aligned and must end at or
    // before the 4KB page boundary it starts in.
    assign w_req_fire   = req_valid & req_ready;
    assign w_misaligned = |(req_addr & c_ALIGN_MASK);
    assign w_span       = (32'(req_len) + 32'd1) << c_SIZE;
    assign w_page_end   = 32'(req_addr[11:0]) + w_span;
    assign w_cross      = (w_page_end > 32'd4096);
    assign w_reject     = w_misaligned | w_cross;
    assign w_start      = w_req_fire & ~w_reject;

    // Completion of each channel counts in the cycle its handshake happens so
    // RESP is entered without an extra bubble.
    assign w_aw_done_next = r_aw_done | (r_aw_valid & axi.AWREADY);
    assign w_b_hs         = axi.BVALID & (r_state == RESP);

    // State register.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_start)                          w_state_next = BURST;
            BURST:   if (w_aw_done_next & w_w_done_next)   w_state_next = RESP;
            RESP:    if (axi.BVALID)                       w_state_next = IDLE;
            default:                                       w_state_next = IDLE;
        endcase
    end

    // Address channel: latch the request and hold AWVALID until accepted.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_aw_valid <= 1'b0;
            r_aw_done  <= 1'b0;
            r_addr     <= '0;
            r_len      <= '0;
        end else if (w_start) begin
            r_aw_valid <= 1'b1;
            r_aw_done  <= 1'b0;
            r_addr     <= req_addr;
            r_len      <= req_len;
        end else if (r_aw_valid & axi.AWREADY) begin
            r_aw_valid <= 1'b0;
            r_aw_done  <= 1'b1;
        end
    end

    // Completion report: one-cycle done pulse for refusal or B handshake.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_done   <= 1'b0;
            r_reject <= 1'b0;
            r_resp   <= RESP_OKAY;
        end else begin
            r_done   <= (w_req_fire & w_reject) | w_b_hs;
            r_reject <= w_req_fire & w_reject;
            if (w_req_fire & w_reject) begin
                r_resp <= RESP_SLVERR;
            end else if (w_b_hs) begin
                r_resp <= axi.BRESP;
            end
        end
    end

    axi_w_stage #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) u_w_stage (
        .clk           (ACLK),
        .rst           (ARESET),
        .i_start       (w_start),
        .i_active      (r_state == BURST),
        .i_len         (r_len),
        .i_wd_valid    (wd_valid),
        .i_wd_data     (wd_data),
        .i_wd_strb     (wd_strb),
        .i_wready      (axi.WREADY),
        .o_wd_ready    (wd_ready),
        .o_wvalid      (w_wvalid),
        .o_wdata       (w_wdata),
        .o_wstrb       (w_wstrb),
        .o_wlast       (w_wlast),
        .o_w_done_next (w_w_done_next)
    );

    assign req_ready   = (r_state == IDLE);
    assign done        = r_done;
    assign reject      = r_reject;
    assign resp        = r_resp;

    assign axi.AWVALID = r_aw_valid;
    assign axi.AWADDR  = r_addr;
    assign axi.AWLEN   = r_len;
    assign axi.AWSIZE  = c_SIZE;
    assign axi.AWBURST = BURST_INCR;
    assign axi.WVALID  = w_wvalid;
    assign axi.WDATA   = w_wdata;
    assign axi.WSTRB   = w_wstrb;
    assign axi.WLAST   = w_wlast;
    assign axi.BREADY  = (r_state == RESP);

endmodule
`default_nettype wire

// File: tb/tb_axi_burst_write.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_burst_write
//  Description : Self-checking bench for axi_burst_write: responsive AXI slave
//                and beat feeder, request-level expected results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_burst_write;
    import axi_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int LEN_W  = 8;
    localparam int MAXB   = 256;

    logic              ACLK = 1'b0;
    logic              ARESET;
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_addr;
    logic [7:0]        req_len;
    logic              wd_valid;
    logic              wd_ready;
    logic [63:0]       wd_data;
    logic [7:0]        wd_strb;
    logic              done;
    logic [1:0]        resp;
    logic              reject;

    axi_burst_write_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) axi ();

    axi_burst_write #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .wd_valid  (wd_valid),
        .wd_ready  (wd_ready),
        .wd_data   (wd_data),
        .wd_strb   (wd_strb),
        .done      (done),
        .resp      (resp),
        .reject    (reject),
        .axi       (axi)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Per-burst configuration written by the main sequence.
    int          cfg_aw_delay = 0;
    int          cfg_stall [MAXB];
    bit          cfg_bubble = 0;
    logic [1:0]  cfg_bresp = 2'b00;
    logic [63:0] feed_data [MAXB];
    logic [7:0]  feed_strb [MAXB];
    int          feed_len = 0;
    int          gen = 0;

    // Observations gathered by the bus model.
    int          m_gen, wd_idx, aw_left, w_left, w_loaded;
    bit          wd_taken, b_taken, need_b, prev_stall;
    logic [63:0] pd;
    logic [7:0]  ps;
    logic        pl;
    logic [63:0] obs_data [MAXB];
    logic [7:0]  obs_strb [MAXB];
    logic        obs_last [MAXB];
    int          obs_n, aw_cnt, stab_err, stall_cyc, bready_early, act_cnt;
    int          done_cnt, done_cyc;
    logic [31:0] aw_addr;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic [1:0]  done_resp;
    logic        done_rej;

    // Bus model: drive on the falling edge, observe 1 time unit later.
    initial begin
        axi.AWREADY = 1'b0; axi.WREADY = 1'b1; axi.BVALID = 1'b0; axi.BRESP = 2'b00;
        wd_valid = 1'b0; wd_data = '0; wd_strb = '0;
        m_gen = 0; wd_idx = 0; aw_left = 0; w_left = 0; w_loaded = -1;
        wd_taken = 0; b_taken = 0; need_b = 0; prev_stall = 0;
        pd = '0; ps = '0; pl = 1'b0;
        obs_n = 0; aw_cnt = 0; stab_err = 0; stall_cyc = 0; bready_early = 0; act_cnt = 0;
        done_cnt = 0; done_cyc = 0; aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = '0;
        done_resp = '0; done_rej = 1'b0;
        forever begin
            @(negedge ACLK);
            if (gen != m_gen) begin
                m_gen = gen; wd_idx = 0; wd_taken = 0; obs_n = 0; aw_cnt = 0;
                stab_err = 0; stall_cyc = 0; bready_early = 0; act_cnt = 0;
                done_cnt = 0; w_loaded = -1; w_left = 0; aw_left = cfg_aw_delay;
            end
            if (wd_taken) begin wd_idx++; wd_taken = 0; end
            if (b_taken) begin axi.BVALID = 1'b0; b_taken = 0; end
            if (ARESET) begin
                wd_idx = feed_len; wd_taken = 0; need_b = 0; prev_stall = 0;
                axi.BVALID = 1'b0; b_taken = 0;
            end
            if (wd_idx < feed_len && (!cfg_bubble || $urandom_range(0, 3) != 0)) begin
                wd_valid = 1'b1; wd_data = feed_data[wd_idx]; wd_strb = feed_strb[wd_idx];
            end else begin
                wd_valid = 1'b0; wd_data = '0; wd_strb = '0;
            end
            if (prev_stall && !(axi.WVALID === 1'b1 && axi.WDATA === pd &&
                                axi.WSTRB === ps && axi.WLAST === pl))
                stab_err++;
            if (axi.AWVALID) begin
                if (aw_left > 0) begin axi.AWREADY = 1'b0; aw_left--; end
                else axi.AWREADY = 1'b1;
            end else begin
                axi.AWREADY = 1'b0; aw_left = cfg_aw_delay;
            end
            if (axi.WVALID) begin
                if (w_loaded != obs_n) begin
                    w_loaded = obs_n;
                    w_left = (obs_n < MAXB) ? cfg_stall[obs_n] : 0;
                end
                if (w_left > 0) begin axi.WREADY = 1'b0; w_left--; end
                else axi.WREADY = 1'b1;
            end else begin
                axi.WREADY = 1'b1;
            end
            if (need_b && !axi.BVALID) begin
                axi.BVALID = 1'b1; axi.BRESP = cfg_bresp; need_b = 0;
            end
            #1;
            if (wd_valid && wd_ready) wd_taken = 1;
            if (axi.AWVALID || axi.WVALID) act_cnt++;
            if (axi.AWVALID && axi.AWREADY) begin
                aw_cnt++; aw_addr = axi.AWADDR; aw_len = axi.AWLEN;
                aw_size = axi.AWSIZE; aw_burst = axi.AWBURST;
            end
            prev_stall = 0;
            if (axi.WVALID && axi.WREADY) begin
                if (obs_n < MAXB) begin
                    obs_data[obs_n] = axi.WDATA; obs_strb[obs_n] = axi.WSTRB;
                    obs_last[obs_n] = axi.WLAST;
                end
                obs_n++;
                if (axi.WLAST) need_b = 1;
            end else if (axi.WVALID) begin
                prev_stall = 1; pd = axi.WDATA; ps = axi.WSTRB; pl = axi.WLAST;
                stall_cyc++;
            end
            if (axi.BVALID && axi.BREADY) b_taken = 1;
            if (axi.BREADY && aw_cnt == 0) bready_early++;
            if (done) begin
                done_cnt++; done_cyc = cyc; done_resp = resp; done_rej = reject;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference rules: beat-aligned start, burst may not pass the 4KB page end.
    function automatic bit model_reject(input logic [31:0] addr, input int len);
        return (addr % 8 != 0) || ((addr % 4096) + (len + 1) * 8 > 4096);
    endfunction

    task automatic prepare(input int len, input int awd, input int stall_mode,
                           input logic [1:0] br, input bit bubble, input bit fixed,
                           input bit feed);
        cfg_aw_delay = awd; cfg_bresp = br; cfg_bubble = bubble;
        for (int i = 0; i < MAXB; i++)
            cfg_stall[i] = (stall_mode == 1) ? int'($urandom_range(0, 2)) : 0;
        if (stall_mode == 2) begin cfg_stall[1] = 3; cfg_stall[4] = 3; end
        for (int i = 0; i <= len; i++) begin
            feed_data[i] = {$urandom, $urandom};
            feed_strb[i] = 8'($urandom);
        end
        if (fixed) begin feed_data[0] = 64'h1122334455667788; feed_strb[0] = 8'hFF; end
        feed_len = feed ? len + 1 : 0;
        gen++;
        repeat (2) @(negedge ACLK);
    endtask

    task automatic issue(input string name, input logic [31:0] addr, input int len,
                         output int acc);
        int lim;
        lim = 0;
        while (!req_ready && lim < 50) begin @(negedge ACLK); lim++; end
        chk({name, "_req_ready"}, req_ready, 1);
        req_valid = 1'b1; req_addr = addr; req_len = 8'(len); acc = cyc;
        @(negedge ACLK);
        req_valid = 1'b0;
    endtask

    task automatic run_burst(input string name, input logic [31:0] addr, input int len,
                             input int awd, input int stall_mode, input logic [1:0] br,
                             input bit bubble, input bit check_lat, input bit fixed);
        bit exp_rej;
        int acc, lim, errs;
        exp_rej = model_reject(addr, len);
        prepare(len, awd, stall_mode, br, bubble, fixed, !exp_rej);
        issue(name, addr, len, acc);
        lim = 0;
        while (done_cnt == 0 && lim < 400) begin @(negedge ACLK); lim++; end
        repeat (4) @(negedge ACLK);
        chk({name, "_done_count"}, done_cnt, 1);
        chk({name, "_reject"}, done_rej, exp_rej);
        chk({name, "_resp"}, done_resp, exp_rej ? RESP_SLVERR : br);
        if (exp_rej) begin
            chk({name, "_rej_latency"}, done_cyc - acc, 1);
            chk({name, "_no_axi_traffic"}, act_cnt, 0);
        end else begin
            if (check_lat) chk({name, "_latency"}, done_cyc - acc, len + 4);
            chk({name, "_aw_count"}, aw_cnt, 1);
            chk({name, "_awaddr"}, aw_addr, addr);
            chk({name, "_awlen"}, aw_len, 8'(len));
            chk({name, "_awsize"}, aw_size, 3'd3);
            chk({name, "_awburst"}, aw_burst, 2'b01);
            chk({name, "_beats"}, obs_n, len + 1);
            errs = 0;
            for (int i = 0; i <= len && i < obs_n; i++)
                if (obs_data[i] !== feed_data[i] || obs_strb[i] !== feed_strb[i] ||
                    obs_last[i] !== (i == len))
                    errs++;
            chk({name, "_beat_content"}, errs, 0);
            chk({name, "_w_stable"}, stab_err, 0);
            chk({name, "_bready_after_aw"}, bready_early, 0);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        logic [31:0] ra;
        int rl;
        req_valid = 1'b0; req_addr = '0; req_len = '0;
        for (int i = 0; i < MAXB; i++) begin cfg_stall[i] = 0; feed_data[i] = '0; feed_strb[i] = '0; end
        ARESET = 1'b1;
        repeat (3) @(negedge ACLK);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_awvalid", axi.AWVALID, 0);
        chk("rst_wvalid", axi.WVALID, 0);
        chk("rst_bready", axi.BREADY, 0);
        chk("rst_wlast", axi.WLAST, 0);
        chk("rst_done", done, 0);
        chk("rst_reject", reject, 0);
        chk("rst_resp", resp, 0);
        ARESET = 1'b0;
        @(negedge ACLK);

        run_burst("single", 32'h8000_0000, 0, 0, 0, RESP_OKAY, 0, 1, 1);
        run_burst("stall8", 32'h8000_0100, 7, 0, 2, RESP_OKAY, 0, 0, 0);
        chk("stall8_stall_cycles", stall_cyc, 6);
        run_burst("awlate", 32'h8000_0200, 3, 10, 0, RESP_OKAY, 0, 0, 0);
        run_burst("rej_cross", 32'h8000_0FF8, 1, 0, 0, RESP_OKAY, 0, 0, 0);
        run_burst("rej_align", 32'h8000_0004, 0, 0, 0, RESP_OKAY, 0, 0, 0);
        run_burst("page_end", 32'h8000_0FF8, 0, 0, 0, RESP_OKAY, 0, 1, 0);
        run_burst("slverr", 32'h8000_0300, 2, 0, 0, RESP_SLVERR, 0, 1, 0);
        run_burst("after_err", 32'h8000_0400, 5, 0, 0, RESP_OKAY, 0, 1, 0);

        // Reset in the middle of a burst.
        prepare(7, 2, 1, RESP_OKAY, 0, 0, 1);
        issue("midrst", 32'h8000_0800, 7, acc);
        repeat (4) @(negedge ACLK);
        ARESET = 1'b1;
        @(negedge ACLK);
        chk("midrst_awvalid", axi.AWVALID, 0);
        chk("midrst_wvalid", axi.WVALID, 0);
        chk("midrst_bready", axi.BREADY, 0);
        chk("midrst_done", done, 0);
        repeat (2) @(negedge ACLK);
        ARESET = 1'b0;
        repeat (3) @(negedge ACLK);
        chk("midrst_req_ready", req_ready, 1);
        chk("midrst_no_done", done_cnt, 0);
        run_burst("post_rst", 32'h8000_0000, 0, 0, 0, RESP_OKAY, 0, 1, 1);

        for (int k = 0; k < 12; k++) begin
            rl = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 0)
                ra = 32'h8000_0000 | (32'($urandom_range(0, 511)) << 3);
            else
                ra = 32'h8000_1000 - 32'h1000 + 32'(4096 - 8 * $urandom_range(1, 20));
            if ($urandom_range(0, 7) == 0) ra = ra | 32'($urandom_range(1, 7));
            run_burst($sformatf("rnd%0d", k), ra, rl, $urandom_range(0, 4), 1,
                      2'($urandom_range(0, 3)), 1, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
